// File: rtl/capture_pkg.sv
// Shared types and record-size math for the packet-capture scheduler and write controller.
package capture_pkg;

    localparam int unsigned REC_HDR_BYTES = 16;
    localparam int unsigned BURST_BYTES   = 16;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned CNT_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE
    } sched_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pkt_begin;
        logic [ADDR_W-1:0] pkt_end;
    } pkt_desc_t;

    // Header plus payload rounded up to the controller burst size.
    function automatic logic [ADDR_W-1:0] rec_stride(input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] padded;
        padded = (ADDR_W'(len) + ADDR_W'(BURST_BYTES - 1)) & ~ADDR_W'(BURST_BYTES - 1);
        return padded + ADDR_W'(REC_HDR_BYTES);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/capture_ring_ptr.sv
// Ring write pointer: holds the current offset, applies pre-issue wrap and post-write advance.
module capture_ring_ptr
    import capture_pkg::*;
(
    input  logic              clk,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] ring_size_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic              wrap_req_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic              wrap_o,
    output logic              fits_c
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] sum_c;

    assign sum_c  = wr_ptr_q + stride_i;
    // Compared against the remaining space so a large stride cannot overflow the sum.
    assign fits_c = (stride_i <= (ring_size_i - wr_ptr_q));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wrap_d   = 1'b0;
        if (wrap_req_i) begin
            wr_ptr_d = '0;
            wrap_d   = 1'b1;
        end else if (advance_i) begin
            if (sum_c == ring_size_i) begin
                wr_ptr_d = '0;
                wrap_d   = 1'b1;
            end else begin
                wr_ptr_d = sum_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign wrap_o   = wrap_q;

endmodule

// File: rtl/capture_sched.sv
// Capture scheduler: places descriptors into the host ring and sequences the write controller.
// Optional WAIT watchdog enabled by defining CAPTURE_SCHED_WDOG_EN.
module capture_sched
    import capture_pkg::*;
`ifdef CAPTURE_SCHED_WDOG_EN
#(
    parameter int unsigned WDOG_CYCLES = 65535
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] ring_base,
    input  logic [ADDR_W-1:0] ring_size,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [ADDR_W-1:0] desc_begin,
    input  logic [ADDR_W-1:0] desc_end,
    output logic              wr_ctrl,
    input  logic              wr_ctrl_rdy,
    output logic [ADDR_W-1:0] control,
    output logic [ADDR_W-1:0] pkt_begin,
    output logic [ADDR_W-1:0] pkt_end,
    output logic [ADDR_W-1:0] write_address,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              wrap,
    output logic              err_timeout
);

    localparam logic [ADDR_W-1:0] CTRL_START = ADDR_W'(1);

    sched_state_t      state_q, state_d;
    pkt_desc_t         desc_q, desc_d;
    logic [LEN_W-1:0]  len_q, len_d, len_c;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] control_q, control_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wr_ctrl_q, wr_ctrl_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              wrap_req_c, advance_c, fits_c, hs_c;

`ifdef CAPTURE_SCHED_WDOG_EN
    localparam int unsigned WDOG_W    = 16;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign desc_ready = reset & (state_q == ST_IDLE) & enable & ~err_timeout;
    assign hs_c       = desc_valid & desc_ready;
    // Packet length is deliberately 16 bits; upper offset bits are discarded.
    assign len_c      = LEN_W'(desc_q.pkt_end - desc_q.pkt_begin);

    capture_ring_ptr u_ring_ptr (
        .clk         (clk),
        .reset_i     (reset),
        .ring_size_i (ring_size),
        .stride_i    (stride_q),
        .wrap_req_i  (wrap_req_c),
        .advance_i   (advance_c),
        .wr_ptr_o    (wr_ptr),
        .wrap_o      (wrap),
        .fits_c      (fits_c)
    );

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        len_d      = len_q;
        stride_d   = stride_q;
        control_d  = control_q;
        waddr_d    = waddr_q;
        wr_ctrl_d  = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        wrap_req_c = 1'b0;
        advance_c  = 1'b0;
`ifdef CAPTURE_SCHED_WDOG_EN
        wdog_d     = '0;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs_c) begin
                    desc_d  = '{pkt_begin: desc_begin, pkt_end: desc_end};
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                len_d    = len_c;
                stride_d = rec_stride(len_c);
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if ((len_q == '0) || (desc_q.pkt_end < desc_q.pkt_begin)) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = ST_IDLE;
                end else if (stride_q > ring_size) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = ST_IDLE;
                end else if (!fits_c) begin
                    wrap_req_c = 1'b1;
                end else begin
                    waddr_d   = ring_base + wr_ptr;
                    control_d = CTRL_START;
                    wr_ctrl_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_ctrl_rdy) begin
                    state_d = ST_ADVANCE;
                end
`ifdef CAPTURE_SCHED_WDOG_EN
                else if (wdog_q == WDOG_LAST) begin
                    err_d      = 1'b1;
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            ST_ADVANCE: begin
                advance_c = 1'b1;
                pkt_cnt_d = sat_inc(pkt_cnt_q);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            desc_q     <= '0;
            len_q      <= '0;
            stride_q   <= '0;
            control_q  <= '0;
            waddr_q    <= '0;
            wr_ctrl_q  <= 1'b0;
            busy_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
`ifdef CAPTURE_SCHED_WDOG_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            len_q      <= len_d;
            stride_q   <= stride_d;
            control_q  <= control_d;
            waddr_q    <= waddr_d;
            wr_ctrl_q  <= wr_ctrl_d;
            busy_q     <= busy_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef CAPTURE_SCHED_WDOG_EN
            wdog_q     <= wdog_d;
            err_q      <= err_d;
`endif
        end
    end

    assign wr_ctrl       = wr_ctrl_q;
    assign control       = control_q;
    assign pkt_begin     = desc_q.pkt_begin;
    assign pkt_end       = desc_q.pkt_end;
    assign write_address = waddr_q;
    assign busy          = busy_q;
    assign pkt_count     = pkt_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_capture_sched.sv
// Scoreboard bench for capture_sched: issues are queued by the driver and checked by a monitor.
module tb_capture_sched;

    logic        clk = 1'b0;
    logic        reset, enable, desc_valid, wr_ctrl_rdy;
    logic [31:0] ring_base, ring_size, desc_begin, desc_end;
    logic        desc_ready, wr_ctrl, busy, wrap, err_timeout;
    logic [31:0] control, pkt_begin, pkt_end, write_address, wr_ptr, pkt_count, drop_count;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int wrap_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] b;
        logic [31:0] e;
        int          c;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_x;

    localparam logic [31:0] BASE = 32'h1000_0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef CAPTURE_SCHED_WDOG_EN
    capture_sched #(.WDOG_CYCLES(8)) dut (
`else
    capture_sched dut (
`endif
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ring_base     (ring_base),
        .ring_size     (ring_size),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_begin    (desc_begin),
        .desc_end      (desc_end),
        .wr_ctrl       (wr_ctrl),
        .wr_ctrl_rdy   (wr_ctrl_rdy),
        .control       (control),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .write_address (write_address),
        .busy          (busy),
        .wr_ptr        (wr_ptr),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count),
        .wrap          (wrap),
        .err_timeout   (err_timeout)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void fail_bound(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endfunction

    // Monitor: every controller start must match the oldest expected issue.
    always @(negedge clk) begin
        if (wrap) wrap_cnt++;
        if (wr_ctrl) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got addr 0x%08h expected no issue", write_address);
            end else begin
                mon_x = sbq.pop_front();
                chk("issue_addr", write_address, mon_x.addr);
                chk("issue_begin", pkt_begin, mon_x.b);
                chk("issue_end", pkt_end, mon_x.e);
                chk("issue_ctrl", control, 32'h1);
                chk("issue_cycle", 32'(cyc), 32'(mon_x.c));
            end
        end
    end

    // Present a descriptor and hold valid until the handshake edge.
    task automatic hs(input logic [31:0] b, input logic [31:0] e, input bit exp_issue,
                      input logic [31:0] exp_addr, input int lat);
        int n;
        n = 0;
        desc_begin = b;
        desc_end   = e;
        desc_valid = 1'b1;
        #1;
        while (!desc_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready) begin
            fail_bound("handshake");
        end else begin
            if (exp_issue) sbq.push_back('{exp_addr, b, e, cyc + lat});
            @(posedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_bound("idle");
        @(negedge clk);
    endtask

    task automatic wait_issue();
        int n;
        n = 0;
        while (!wr_ctrl && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ctrl) fail_bound("issue");
    endtask

    task automatic finish_rec(input bit exp_issue);
        @(negedge clk);
        desc_valid = 1'b0;
        if (exp_issue) begin
            wait_issue();
            @(negedge clk);
            @(negedge clk);
            wr_ctrl_rdy = 1'b1;
            @(negedge clk);
            wr_ctrl_rdy = 1'b0;
        end
        wait_idle();
    endtask

    task automatic send(input logic [31:0] b, input logic [31:0] e, input bit exp_issue,
                        input logic [31:0] exp_addr, input int lat);
        hs(b, e, exp_issue, exp_addr, lat);
        finish_rec(exp_issue);
    endtask

    task automatic chk_state(input string nm, input logic [31:0] ptr, input logic [31:0] pk,
                             input logic [31:0] dr);
        chk({nm, "_wr_ptr"}, wr_ptr, ptr);
        chk({nm, "_pkt_count"}, pkt_count, pk);
        chk({nm, "_drop_count"}, drop_count, dr);
    endtask

    initial begin
        int wc0;
        bit early;
        reset       = 1'b0;
        enable      = 1'b0;
        desc_valid  = 1'b0;
        wr_ctrl_rdy = 1'b0;
        ring_base   = BASE;
        ring_size   = 32'h1000;
        desc_begin  = '0;
        desc_end    = '0;
        repeat (3) @(negedge clk);

        chk_state("reset", 32'h0, 32'h0, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wr_ctrl", 32'(wr_ctrl), 32'h0);
        chk("reset_waddr", write_address, 32'h0);
        chk("reset_control", control, 32'h0);
        chk("reset_err", 32'(err_timeout), 32'h0);
        chk("reset_ready", 32'(desc_ready), 32'h0);

        reset = 1'b1;
        @(negedge clk);
        chk("ready_disabled", 32'(desc_ready), 32'h0);
        enable = 1'b1;
        #1;
        chk("ready_enabled", 32'(desc_ready), 32'h1);
        @(negedge clk);

        // Single packet, then rounding.
        wc0 = wrap_cnt;
        send(32'h0, 32'h40, 1'b1, BASE, 3);
        chk_state("single", 32'h50, 32'h1, 32'h0);
        send(32'h100, 32'h13D, 1'b1, BASE + 32'h50, 3);
        chk_state("round", 32'hA0, 32'h2, 32'h0);
        chk("no_wrap_yet", 32'(wrap_cnt - wc0), 32'h0);

        // Wrap before issue, then exact fill.
        send(32'h0, 32'hF10, 1'b1, BASE + 32'hA0, 3);
        chk_state("to_fc0", 32'hFC0, 32'h3, 32'h0);
        wc0 = wrap_cnt;
        send(32'h0, 32'h40, 1'b1, BASE, 4);
        chk_state("wrap", 32'h50, 32'h4, 32'h0);
        chk("wrap_pulse", 32'(wrap_cnt - wc0), 32'h1);
        wc0 = wrap_cnt;
        send(32'h0, 32'hFA0, 1'b1, BASE + 32'h50, 3);
        chk_state("fill", 32'h0, 32'h5, 32'h0);
        chk("fill_wrap_pulse", 32'(wrap_cnt - wc0), 32'h1);

        // Drops.
        send(32'h20, 32'h20, 1'b0, 32'h0, 0);
        chk_state("drop_len0", 32'h0, 32'h5, 32'h1);
        send(32'h40, 32'h20, 1'b0, 32'h0, 0);
        chk_state("drop_rev", 32'h0, 32'h5, 32'h2);
        send(32'h0, 32'h1000, 1'b0, 32'h0, 0);
        chk_state("drop_big", 32'h0, 32'h5, 32'h3);

        // Stray ready in IDLE.
        wr_ctrl_rdy = 1'b1;
        @(negedge clk);
        wr_ctrl_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_busy", 32'(busy), 32'h0);
        chk_state("stray", 32'h0, 32'h5, 32'h3);

        // Back-to-back with valid held throughout.
        early = 1'b0;
        hs(32'h0, 32'h40, 1'b1, BASE, 3);
        @(negedge clk);
        desc_begin = 32'h200;
        desc_end   = 32'h240;
        for (int i = 0; i < 20 && !wr_ctrl; i++) begin
            early |= desc_ready;
            @(negedge clk);
        end
        @(negedge clk);
        early |= desc_ready;
        wr_ctrl_rdy = 1'b1;
        @(negedge clk);
        early |= desc_ready;
        wr_ctrl_rdy = 1'b0;
        @(negedge clk);
        chk("b2b_early_ready", 32'(early), 32'h0);
        chk("b2b_ready_after_adv", 32'(desc_ready), 32'h1);
        chk("b2b_pkt_at_hs2", pkt_count, 32'h6);
        hs(32'h200, 32'h240, 1'b1, BASE + 32'h50, 3);
        finish_rec(1'b1);
        chk_state("b2b", 32'hA0, 32'h7, 32'h3);

        // Reset while waiting for the controller.
        hs(32'h0, 32'h40, 1'b1, BASE + 32'hA0, 3);
        @(negedge clk);
        desc_valid = 1'b0;
        wait_issue();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_state("rst_wait", 32'h0, 32'h0, 32'h0);
        chk("rst_wait_busy", 32'(busy), 32'h0);
        chk("rst_wait_wr_ctrl", 32'(wr_ctrl), 32'h0);
        chk("rst_wait_waddr", write_address, 32'h0);
        chk("rst_wait_begin", pkt_begin, 32'h0);
        chk("rst_wait_control", control, 32'h0);
        chk("rst_wait_ready", 32'(desc_ready), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        send(32'h0, 32'h40, 1'b1, BASE, 3);
        chk_state("recover", 32'h50, 32'h1, 32'h0);

`ifdef CAPTURE_SCHED_WDOG_EN
        begin
            int ci;
            int n;
            bool_block: begin
                int ready_hi;
                hs(32'h0, 32'h40, 1'b1, BASE + 32'h50, 3);
                @(negedge clk);
                desc_valid = 1'b0;
                wait_issue();
                ci = cyc;
                n  = 0;
                while (!err_timeout && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                if (!err_timeout) fail_bound("watchdog");
                chk("wdog_cycle", 32'(cyc), 32'(ci + 9));
                chk_state("wdog", 32'h50, 32'h1, 32'h1);
                chk("wdog_busy", 32'(busy), 32'h0);
                desc_valid = 1'b1;
                ready_hi   = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (desc_ready) ready_hi++;
                end
                desc_valid = 1'b0;
                chk("wdog_ready_blocked", 32'(ready_hi), 32'h0);
                chk("wdog_err_sticky", 32'(err_timeout), 32'h1);
            end
        end
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
